// File: rtl/pipe_float2fixedpoint.sv
// pipe_float2fixedpoint: three-stage IEEE-754 single-precision to WOI.WOF
// two's-complement fixed-point converter with valid/ready handshaking.
//   S1 decodes the float and works out how far to shift the significand.
//   S2 aligns the significand to the output grid and rounds the magnitude.
//   S3 applies the sign and resolves overflow (saturate or wrap).
module pipe_float2fixedpoint #(
    parameter int WOI   = 8,   // integer bits including sign, 2..32
    parameter int WOF   = 8,   // fraction bits, 0..32
    parameter int ROOF  = 1,   // 1: saturate on overflow, 0: wrap
    parameter int ROUND = 1    // 1: round half away from zero, 0: truncate
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [31:0]            in,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [WOI+WOF-1:0]     out,
    output logic                   upflow,
    output logic                   downflow
);

    localparam int N  = WOI + WOF;  // output word width
    localparam int AW = N + 1;      // aligned magnitude: output LSBs plus one round bit
    localparam int SW = AW + 24;    // 24-bit significand shifted left by at most AW

    // Largest positive magnitude, and largest negative magnitude (which is one more)
    localparam logic [N:0]   LIM_POS = {2'b00, {(N-1){1'b1}}};
    localparam logic [N:0]   LIM_NEG = {2'b01, {(N-1){1'b0}}};
    localparam logic [N-1:0] MAX_OUT = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_OUT = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        CLS_ZERO,      // zero or denormal: flushes to 0
        CLS_NORM,      // ordinary normal number
        CLS_POS_SPEC,  // +Inf or any NaN: forced positive overflow
        CLS_NEG_SPEC   // -Inf: forced negative overflow
    } cls_t;

    // ---------------- pipeline state ----------------
    logic        s1_v_q, s1_sign_q, s1_left_q, s1_big_q;
    cls_t        s1_cls_q;
    logic [23:0] s1_mant_q;
    logic [7:0]  s1_amt_q;

    logic        s2_v_q, s2_sign_q, s2_big_q;
    cls_t        s2_cls_q;
    logic [N:0]  s2_mag_q;

    logic        s3_v_q;

    // ---------------- handshake ----------------
    // A stage may load when it is empty or its contents move on this cycle.
    logic en1, en2, en3;
    assign en3     = !s3_v_q || o_ready;
    assign en2     = !s2_v_q || en3;
    assign en1     = !s1_v_q || en2;
    assign i_ready = en1;
    assign o_valid = s3_v_q;

    // ---------------- S1: decode ----------------
    int          s1_sh;
    cls_t        s1_cls_d;
    logic        s1_left_d, s1_big_d;
    logic [7:0]  s1_amt_d;

    // Classify the input and compute the significand shift onto the round-bit grid
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        // The 24-bit significand has LSB weight 2^(exp-150); the aligned grid has
        // LSB weight 2^-(WOF+1). Positive shift = left, negative = right.
        s1_sh     = int'(in[30:23]) - 149 + WOF;
        // Leading one lands at bit 23+shift; at or above AW the magnitude is >= 2^WOI.
        s1_big_d  = (s1_sh + 23) >= AW;
        s1_left_d = 1'b0;
        s1_amt_d  = '0;
        if (s1_sh >= 0) begin
            // Beyond AW every significand bit falls off the kept window anyway
            s1_left_d = 1'b1;
            s1_amt_d  = 8'((s1_sh > AW) ? AW : s1_sh);
        end else begin
            // Beyond 24 the whole significand is shifted out
            s1_amt_d  = 8'((-s1_sh > 24) ? 24 : -s1_sh);
        end

        s1_cls_d = CLS_NORM;
        if (in[30:23] == 8'd0) begin
            s1_cls_d = CLS_ZERO;
        end else if (in[30:23] == 8'hFF) begin
            s1_cls_d = (!in[31] || (in[22:0] != '0)) ? CLS_POS_SPEC : CLS_NEG_SPEC;
        end
    end

    // S1 register: capture the decoded word on an input transfer
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every stage samples pre-edge values.
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_left_q <= 1'b0;
            s1_big_q  <= 1'b0;
            s1_cls_q  <= CLS_ZERO;
            s1_mant_q <= '0;
            s1_amt_q  <= '0;
        end else if (en1) begin
            s1_v_q    <= i_valid;
            s1_sign_q <= in[31];
            s1_left_q <= s1_left_d;
            s1_big_q  <= s1_big_d;
            s1_cls_q  <= s1_cls_d;
            s1_mant_q <= {1'b1, in[22:0]};
            s1_amt_q  <= s1_amt_d;
        end
    end

    // ---------------- S2: align and round ----------------
    logic [SW-1:0] s2_wide;
    logic [AW-1:0] s2_aligned;
    logic [N:0]    s2_mag_d;
    logic          s2_big_d;

    // Shift the significand onto the grid, then round away the extra LSB
    always_comb begin
        s2_wide    = {{AW{1'b0}}, s1_mant_q};
        s2_aligned = AW'(s1_left_q ? (s2_wide << s1_amt_q) : (s2_wide >> s1_amt_q));
        // One spare MSB catches the carry out of rounding
        s2_mag_d   = {1'b0, s2_aligned[AW-1:1]};
        if (ROUND != 0) begin
            s2_mag_d = s2_mag_d + {{N{1'b0}}, s2_aligned[0]};
        end
        s2_big_d   = s1_big_q;
        if (s1_cls_q != CLS_NORM) begin
            s2_mag_d = '0;
            s2_big_d = 1'b0;
        end
    end

    // S2 register: hold the rounded magnitude
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_q    <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_big_q  <= 1'b0;
            s2_cls_q  <= CLS_ZERO;
            s2_mag_q  <= '0;
        end else if (en2) begin
            s2_v_q    <= s1_v_q;
            s2_sign_q <= s1_sign_q;
            s2_big_q  <= s2_big_d;
            s2_cls_q  <= s1_cls_q;
            s2_mag_q  <= s2_mag_d;
        end
    end

    // ---------------- S3: sign and overflow ----------------
    logic [N-1:0] s3_low, s3_wrap, s3_out_d;
    logic         s3_pos_ovf, s3_neg_ovf, s3_up_d, s3_dn_d;

    // Negate after rounding; saturate or keep the low bits on overflow
    always_comb begin
        s3_low     = s2_mag_q[N-1:0];
        s3_wrap    = s2_sign_q ? (~s3_low + N'(1)) : s3_low;
        s3_pos_ovf = !s2_sign_q && (s2_big_q || (s2_mag_q > LIM_POS));
        s3_neg_ovf =  s2_sign_q && (s2_big_q || (s2_mag_q > LIM_NEG));
        s3_out_d   = s3_wrap;
        s3_up_d    = 1'b0;
        s3_dn_d    = 1'b0;
        case (s2_cls_q)
            CLS_ZERO: s3_out_d = '0;
            // Inf/NaN have no meaningful low bits, so they always clamp
            CLS_POS_SPEC: begin
                s3_out_d = MAX_OUT;
                s3_up_d  = 1'b1;
            end
            CLS_NEG_SPEC: begin
                s3_out_d = MIN_OUT;
                s3_dn_d  = 1'b1;
            end
            default: begin
                s3_up_d = s3_pos_ovf;
                s3_dn_d = s3_neg_ovf;
                if (ROOF != 0 && s3_pos_ovf) begin
                    s3_out_d = MAX_OUT;
                end else if (ROOF != 0 && s3_neg_ovf) begin
                    s3_out_d = MIN_OUT;
                end
            end
        endcase
    end

    // S3 register: output word, held stable while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_v_q   <= 1'b0;
            out      <= '0;
            upflow   <= 1'b0;
            downflow <= 1'b0;
        end else if (en3) begin
            s3_v_q   <= s2_v_q;
            out      <= s3_out_d;
            upflow   <= s3_up_d;
            downflow <= s3_dn_d;
        end
    end

endmodule

// File: tb/tb_pipe_float2fixedpoint.sv
// tb_pipe_float2fixedpoint: scoreboard bench for two converter builds fed
// from the same stream: A = saturate/round, B = wrap/truncate (both 8.8).
module tb_pipe_float2fixedpoint;

    logic        clk = 1'b0;
    logic        rst, i_valid, o_ready;
    logic [31:0] in_w;
    logic        i_ready_a, o_valid_a, up_a, dn_a;
    logic        i_ready_b, o_valid_b, up_b, dn_b;
    logic [15:0] out_a, out_b;

    always #5 clk = ~clk;

    pipe_float2fixedpoint #(.WOI(8), .WOF(8), .ROOF(1), .ROUND(1)) u_a (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_a), .in(in_w),
        .o_valid(o_valid_a), .o_ready(o_ready), .out(out_a),
        .upflow(up_a), .downflow(dn_a));

    pipe_float2fixedpoint #(.WOI(8), .WOF(8), .ROOF(0), .ROUND(0)) u_b (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_b), .in(in_w),
        .o_valid(o_valid_b), .o_ready(o_ready), .out(out_b),
        .upflow(up_b), .downflow(dn_b));

    // Expected result: {out, upflow, downflow}
    typedef struct packed {
        logic [15:0] o;
        logic        up;
        logic        dn;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic        stall_a = 1'b0, stall_b = 1'b0;
    logic [17:0] held_a, held_b;

    // Directed vectors: input, expected A, expected B ({out, up, dn})
    localparam int ND = 18;
    logic [31:0] d_in [ND] = '{
        32'h3FC00000, 32'hBFC00000, 32'h43480000, 32'hC3480000, 32'hC3000000,
        32'h7FC00000, 32'h3B000000, 32'h00000001, 32'h7F800000, 32'hFF800000,
        32'h00000000, 32'h3B400000, 32'hBC200000, 32'h42FFFE00, 32'h43000000,
        32'hC3000100, 32'h42FFFF00, 32'h80000000};
    logic [17:0] d_a [ND] = '{
        {16'h0180, 2'b00}, {16'hFE80, 2'b00}, {16'h7FFF, 2'b10}, {16'h8000, 2'b01},
        {16'h8000, 2'b00}, {16'h7FFF, 2'b10}, {16'h0001, 2'b00}, {16'h0000, 2'b00},
        {16'h7FFF, 2'b10}, {16'h8000, 2'b01}, {16'h0000, 2'b00}, {16'h0001, 2'b00},
        {16'hFFFD, 2'b00}, {16'h7FFF, 2'b00}, {16'h7FFF, 2'b10}, {16'h8000, 2'b01},
        {16'h7FFF, 2'b10}, {16'h0000, 2'b00}};
    logic [17:0] d_b [ND] = '{
        {16'h0180, 2'b00}, {16'hFE80, 2'b00}, {16'hC800, 2'b10}, {16'h3800, 2'b01},
        {16'h8000, 2'b00}, {16'h7FFF, 2'b10}, {16'h0000, 2'b00}, {16'h0000, 2'b00},
        {16'h7FFF, 2'b10}, {16'h8000, 2'b01}, {16'h0000, 2'b00}, {16'h0000, 2'b00},
        {16'hFFFE, 2'b00}, {16'h7FFF, 2'b00}, {16'h8000, 2'b10}, {16'h7FFF, 2'b01},
        {16'h7FFF, 2'b00}, {16'h0000, 2'b00}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r / 2.0;
        return r;
    endfunction

    // Reference conversion for 8.8 output, computed from the real value
    function automatic exp_t model(input logic [31:0] f, input bit roof, input bit rnd);
        exp_t   e;
        real    m, q;
        longint v;
        e = '0;
        if (f[30:23] == 8'd0) return e;
        if (f[30:23] == 8'hFF) begin
            if (!f[31] || f[22:0] != 0) begin e.o = 16'h7FFF; e.up = 1'b1; end
            else                        begin e.o = 16'h8000; e.dn = 1'b1; end
            return e;
        end
        m = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(int'(f[30:23]) - 127 + 8);
        q = rnd ? $floor(m + 0.5) : $floor(m);
        v = longint'($rtoi(q));
        if (f[31]) v = -v;
        if (v > 32767) begin
            e.up = 1'b1;
            e.o  = roof ? 16'h7FFF : 16'(v);
        end else if (v < -32768) begin
            e.dn = 1'b1;
            e.o  = roof ? 16'h8000 : 16'(v);
        end else begin
            e.o = 16'(v);
        end
        return e;
    endfunction

    // One clock cycle: drive at negedge, sample 1ns later, score output transfers
    task automatic cycle(input bit v, input logic [31:0] w, input bit rdy,
                         output bit took, output bit ov);
        exp_t e;
        @(negedge clk);
        i_valid = v;
        in_w    = w;
        o_ready = rdy;
        #1;
        if (stall_a) check("stall_hold_a", {14'd0, o_valid_a, out_a, up_a, dn_a}, {14'd0, 1'b1, held_a});
        if (stall_b) check("stall_hold_b", {14'd0, o_valid_b, out_b, up_b, dn_b}, {14'd0, 1'b1, held_b});
        if (o_valid_a && rdy) begin
            if (q_a.size() == 0) check("spurious_out_a", o_valid_a, 0);
            else begin
                e = q_a.pop_front();
                check("out_a", out_a, e.o);
                check("upflow_a", up_a, e.up);
                check("downflow_a", dn_a, e.dn);
            end
        end
        if (o_valid_b && rdy) begin
            if (q_b.size() == 0) check("spurious_out_b", o_valid_b, 0);
            else begin
                e = q_b.pop_front();
                check("out_b", out_b, e.o);
                check("upflow_b", up_b, e.up);
                check("downflow_b", dn_b, e.dn);
            end
        end
        stall_a = o_valid_a && !rdy;
        stall_b = o_valid_b && !rdy;
        held_a  = {out_a, up_a, dn_a};
        held_b  = {out_b, up_b, dn_b};
        took    = v && i_ready_a;
        ov      = o_valid_a;
    endtask

    task automatic send(input logic [31:0] w, input exp_t ea, input exp_t eb, input bit rnd_rdy);
        bit took = 1'b0, ov;
        int n = 0;
        while (!took && n < 50) begin
            cycle(1'b1, w, rnd_rdy ? ($urandom_range(0, 9) < 7) : 1'b1, took, ov);
            n++;
        end
        if (took) begin
            q_a.push_back(ea);
            q_b.push_back(eb);
        end else begin
            check("send_timeout", took, 1);
        end
    endtask

    task automatic drain();
        bit t, ov;
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 40) begin
            cycle(1'b0, 32'h0, 1'b1, t, ov);
            n++;
        end
        check("drain_pending", q_a.size() + q_b.size(), 0);
    endtask

    // Single word into an idle pipe: o_valid must rise on the third cycle
    task automatic latency_test(input int idx);
        bit took, ov;
        cycle(1'b1, d_in[idx], 1'b1, took, ov);
        check("lat_accept", took, 1);
        if (took) begin
            q_a.push_back(exp_t'(d_a[idx]));
            q_b.push_back(exp_t'(d_b[idx]));
        end
        cycle(1'b0, 32'h0, 1'b1, took, ov);
        check("lat_cycle1_ovalid", ov, 0);
        cycle(1'b0, 32'h0, 1'b1, took, ov);
        check("lat_cycle2_ovalid", ov, 0);
        cycle(1'b0, 32'h0, 1'b1, took, ov);
        check("lat_cycle3_ovalid", ov, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ovalid_a"}, o_valid_a, 0);
        check({tag, "_ovalid_b"}, o_valid_b, 0);
        check({tag, "_iready"}, i_ready_a, 1);
        check({tag, "_out_a"}, {out_a, up_a, dn_a}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          took, ov, blocked;
        int          k, cyc;
        logic [31:0] w;

        rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; in_w = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("reset");

        latency_test(0);
        drain();

        // Directed values, back-to-back with o_ready high
        for (int i = 0; i < ND; i++) send(d_in[i], exp_t'(d_a[i]), exp_t'(d_b[i]), 1'b0);
        drain();

        // Six words streamed while o_ready is low in cycles 2..6
        k = 0; blocked = 1'b0; cyc = 1;
        while ((k < 6 || q_a.size() != 0) && cyc < 60) begin
            cycle(k < 6, d_in[k % ND], !(cyc >= 2 && cyc <= 6), took, ov);
            if (k < 6 && !took) blocked = 1'b1;
            if (took) begin
                q_a.push_back(exp_t'(d_a[k]));
                q_b.push_back(exp_t'(d_b[k]));
                k++;
            end
            check("inflight_le3", q_a.size() <= 3, 1);
            cyc++;
        end
        check("bp_iready_dropped", blocked, 1);
        check("bp_all_accepted", k, 6);
        drain();

        // Random values with random backpressure, scored against the real-valued model
        for (int i = 0; i < 60; i++) begin
            w = {1'($urandom), 8'($urandom_range(110, 145)), 23'($urandom)};
            send(w, model(w, 1'b1, 1'b1), model(w, 1'b0, 1'b0), 1'b1);
        end
        drain();

        // Two words in flight, then a one-cycle reset with a competing input
        cycle(1'b1, 32'h3FC00000, 1'b1, took, ov);
        cycle(1'b1, 32'hBFC00000, 1'b1, took, ov);
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b1; in_w = 32'h43480000; o_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; i_valid = 1'b0;
        stall_a = 1'b0; stall_b = 1'b0;
        #1;
        check_idle("midrst");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b1, took, ov);
            check("post_rst_quiet", ov, 0);
        end
        latency_test(2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_float2fixedpoint.md
PIPE_FLOAT2FIXEDPOINT -- requirements
Module: pipe_float2fixedpoint

Interface
REQ-001 Parameter WOI, default 8: output integer bits incl. sign, 2..32.
REQ-002 Parameter WOF, default 8: output fraction bits, 0..32.
REQ-003 Parameter ROOF, default 1: 1 = saturate on overflow; 0 = wrap, keeping low WOI+WOF bits.
REQ-004 Parameter ROUND, default 1: 1 = round half away from zero; 0 = truncate magnitude toward zero.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 i_valid  input  1  input word valid.
REQ-008 i_ready  output  1  block can accept input this cycle.
REQ-009 in  input  32  IEEE-754 single: sign[31], exp[30:23], mant[22:0].
REQ-010 o_valid  output  1  output word valid.
REQ-011 o_ready  input  1  downstream accepts output this cycle.
REQ-012 out  output  WOI+WOF  two's-complement fixed point, WOI.WOF.
REQ-013 upflow  output  1  positive overflow or +Inf/NaN; qualified by o_valid.
REQ-014 downflow  output  1  negative overflow or -Inf; qualified by o_valid.
REQ-015 One clock; reset synchronous, active-high; ports named clk and rst.

Function
REQ-016 Transfer in = i_valid & i_ready; transfer out = o_valid & o_ready.
REQ-017 Three register stages: S1 decode/shift amount, S2 align/round, S3 negate/saturate; latency 3 cycles from input transfer to o_valid when o_ready held high.
REQ-018 Each stage advances when it is empty or the next stage advances; i_ready = S1 empty or S1 advancing; full throughput 1 word/cycle.
REQ-019 Backpressure: with o_ready low, S3 holds out/flags stable; at most 3 words in flight; no loss, duplication or reordering.
REQ-020 exp==0 (zero/denormal): result 0, no flags.
REQ-021 Normal: magnitude = 1.mant * 2^(exp-127), aligned to WOF fraction bits with an internal intermediate wide enough for exact shifting plus one round bit and an overflow-sticky bit.
REQ-022 ROUND=1: add 1 LSB if first discarded bit is 1; ROUND=0: drop discarded bits.
REQ-023 Negative inputs: negate rounded magnitude after rounding.
REQ-024 Max = 2^(WOI-1) - 2^-WOF; min = -2^(WOI-1); negative magnitude exactly 2^(WOI-1) is representable, no flag.
REQ-025 Rounded value > max: upflow=1; out = max if ROOF, else low bits. Rounded value < min: downflow=1; out = min if ROOF, else low bits.
REQ-026 exp==255: mant==0 & sign==0 or mant!=0 (NaN) -> upflow path; mant==0 & sign==1 -> downflow path.
REQ-027 Magnitudes below 2^-(WOF+1) produce 0, no flags; upflow and downflow never both 1.

Reset
REQ-028 rst=1 clears all stage-valid bits: o_valid=0, i_ready=1 the cycle after rst deasserts; out, upflow, downflow = 0.
REQ-029 rst during activity discards all in-flight words; no output for them after reset.
REQ-030 rst has priority over any transfer in the same cycle.

Verification (WOI=8, WOF=8, ROOF=1, ROUND=1 unless stated)
REQ-031 in=0x3FC00000 (1.5), o_ready=1 -> 3 cycles later out=0x0180, no flags; in=0xBFC00000 -> 0xFE80.
REQ-032 in=0x43480000 (200.0) -> out=0x7FFF, upflow=1; 0xC3480000 -> 0x8000, downflow=1; 0xC3000000 (-128.0) -> 0x8000, no flag; 0x7FC00000 (NaN) -> 0x7FFF, upflow=1.
REQ-033 in=0x3B000000 (2^-9): ROUND=1 -> 0x0001; ROUND=0 -> 0x0000; 0x00000001 (denormal) -> 0x0000; 200.0 with ROOF=0 -> 0xC800, upflow=1.
REQ-034 Stream 6 words back-to-back, o_ready low cycles 2-6 -> i_ready low once 3 words held; all 6 outputs emerge in order, each exactly once, values held stable while stalled.
REQ-035 2 words in flight, rst pulsed 1 cycle -> o_valid stays 0, i_ready=1 after reset; next input emerges with 3-cycle latency.
